// File: rtl/filt_sample_queue.sv
// Circular sample store for the FIR filters: keeps the last SEQ_LEN stereo samples
// and replays the window oldest-first, one per clock, after each new sample.
module filt_sample_queue #(
  parameter int DEPTH   = 1024,
  parameter int SEQ_LEN = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [15:0] lft_in,
  input  logic [15:0] rght_in,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        full,
  output logic        overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(SEQ_LEN + 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] SEQ_DONE  = CW'(SEQ_LEN);

  typedef enum logic [1:0] {FILL, IDLE, START, SEQ} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   new_ptr_q, new_ptr_d;
  logic [PW-1:0]   old_ptr_q, old_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   seq_cnt_q, seq_cnt_d;
  logic            seq_q, seq_d;
  logic            full_q, full_d;
  logic            overrun_q, overrun_d;
  logic            wr_en, rd_en;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_data_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    seq_cnt_d = seq_cnt_q;
    seq_d     = 1'b0;
    full_d    = full_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;

    case (state_q)
      FILL: if (valid) begin
        wr_en     = 1'b1;
        new_ptr_d = new_ptr_q + 1'b1;
        count_d   = count_q + 1'b1;
        if (count_q == FILL_LAST) begin
          full_d  = 1'b1;
          state_d = START;
        end
      end
      IDLE: if (valid) begin
        wr_en     = 1'b1;
        new_ptr_d = new_ptr_q + 1'b1;
        old_ptr_d = old_ptr_q + 1'b1;
        state_d   = START;
      end
      START: begin
        rd_ptr_d  = old_ptr_q;
        seq_cnt_d = '0;
        state_d   = SEQ;
      end
      SEQ: begin
        if (seq_cnt_q == SEQ_DONE) begin
          state_d = IDLE;
        end else begin
          rd_en     = 1'b1;
          seq_d     = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    // Samples arriving mid-replay are dropped; the flag tells the system it lost data.
    if (valid && (state_q == START || state_q == SEQ)) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      seq_cnt_q <= '0;
      seq_q     <= 1'b0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      seq_cnt_q <= seq_cnt_d;
      seq_q     <= seq_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: the sample RAM and its read register are deliberately not reset; stale data is masked by seq_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem[new_ptr_q] <= {lft_in, rght_in};
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  assign sequencing = seq_q;
  assign lft_out    = seq_q ? rd_data_q[31:16] : 16'h0000;
  assign rght_out   = seq_q ? rd_data_q[15:0]  : 16'h0000;
  assign full       = full_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_filt_sample_queue.sv
// Bench for filt_sample_queue: a small (8/5) and a default (1024/1021) instance share
// one stimulus stream and are compared every cycle against a sample-history model.
module tb_filt_sample_queue;

  localparam int SLOTS = 4096;
  localparam int HIST  = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] lft_in, rght_in;
  logic        seq_o  [2];
  logic [15:0] lo     [2];
  logic [15:0] ro     [2];
  logic        full_o [2];
  logic        ovr_o  [2];

  filt_sample_queue #(.DEPTH(8), .SEQ_LEN(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lft_in(lft_in), .rght_in(rght_in),
    .sequencing(seq_o[0]), .lft_out(lo[0]), .rght_out(ro[0]),
    .full(full_o[0]), .overrun(ovr_o[0])
  );

  filt_sample_queue dut_d (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lft_in(lft_in), .rght_in(rght_in),
    .sequencing(seq_o[1]), .lft_out(lo[1]), .rght_out(ro[1]),
    .full(full_o[1]), .overrun(ovr_o[1])
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          len     [2];
  int          hcnt    [2];
  int          next_ok [2];
  bit          ovr_m   [2];
  logic [31:0] hist    [2][HIST];
  bit          exp_v   [2][SLOTS];
  logic [31:0] exp_d   [2][SLOTS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      hcnt[id] = 0; next_ok[id] = 0; ovr_m[id] = 1'b0;
      for (int s = 0; s < SLOTS; s++) exp_v[id][s] = 1'b0;
    end
  endtask

  // Accepted sample -> append to history; once SEQ_LEN are held, schedule the
  // newest SEQ_LEN samples oldest-first on cycles k+2 .. k+1+SEQ_LEN.
  task automatic model_edge();
    if (!rst_n || !valid) return;
    for (int id = 0; id < 2; id++) begin
      if (cyc >= next_ok[id]) begin
        hist[id][hcnt[id] % HIST] = {lft_in, rght_in};
        hcnt[id]++;
        if (hcnt[id] >= len[id]) begin
          for (int i = 0; i < len[id]; i++) begin
            exp_v[id][(cyc + 2 + i) % SLOTS] = 1'b1;
            exp_d[id][(cyc + 2 + i) % SLOTS] = hist[id][(hcnt[id] - len[id] + i) % HIST];
          end
          next_ok[id] = cyc + len[id] + 3;
        end
      end else begin
        ovr_m[id] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    int          slot;
    logic [31:0] ed;
    slot = cyc % SLOTS;
    for (int id = 0; id < 2; id++) begin
      ed = exp_v[id][slot] ? exp_d[id][slot] : 32'h0;
      check($sformatf("seq%0d@%0d", id, cyc),  {31'h0, seq_o[id]},  {31'h0, exp_v[id][slot]});
      check($sformatf("lft%0d@%0d", id, cyc),  {16'h0, lo[id]},     {16'h0, ed[31:16]});
      check($sformatf("rght%0d@%0d", id, cyc), {16'h0, ro[id]},     {16'h0, ed[15:0]});
      check($sformatf("full%0d@%0d", id, cyc), {31'h0, full_o[id]}, {31'h0, hcnt[id] >= len[id]});
      check($sformatf("ovr%0d@%0d", id, cyc),  {31'h0, ovr_o[id]},  {31'h0, ovr_m[id]});
      exp_v[id][slot] = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r);
    valid = v; lft_in = l; rght_in = r;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0);
  endtask

  task automatic push(input int n);
    step(1'b1, 16'(n), 16'(-n));
  endtask

  // Called just after a check: drops reset mid-cycle and verifies the async clear.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    idle(2);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    len[0] = 5; len[1] = 1021;
    rst_n = 1'b0; valid = 1'b0; lft_in = '0; rght_in = '0;
    model_reset();
    idle(2);
    #2 rst_n = 1'b1;
    idle(3);

    // Fill 1..5, then first replay.
    for (int n = 1; n <= 5; n++) begin push(n); idle(1); end
    idle(8);
    // Replays with pointer wrap, each valid after the previous replay.
    for (int n = 6; n <= 9; n++) begin push(n); idle(8); end
    // Valid during SEQ is dropped.
    push(10); idle(2); push(99); idle(6);
    // Valid on the edge SEQ finishes: dropped.
    push(11); idle(6); push(98); idle(8);
    // Valid with exactly a one-cycle gap after replay end: accepted.
    push(12); idle(7); push(13); idle(8);

    // Random traffic.
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom));
    idle(8);

    // Reset on the third sequencing cycle, then refill.
    push(20); idle(4);
    async_reset();
    for (int n = 21; n <= 24; n++) begin push(n); idle(2); end
    idle(8);
    push(25); idle(8);

    // Default-size ramp fill and full-length replays.
    async_reset();
    for (int n = 1; n <= 1021; n++) push(n);
    idle(1030);
    push(1022); idle(1022); push(1023); idle(1025);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
